tdm_demux4: RTL and testbench

- Receive-side counterpart of the 4:1 selector path: a 4-lane time-division demultiplexer.
- Takes one W-bit word stream in which lane 0..3 words arrive in rotating slots, with lane 0 flagged by `sync`.
- Distributes each word to a per-lane holding register and strobes when a complete frame (lanes 0-3) has been captured.
- Sits at the far end of a shared link driven by a slot-rotating mux.

---
 rtl/tdm_demux4_pkg.sv | 13 +
 rtl/tdm_demux4_demux2.sv | 12 +
 rtl/tdm_demux4.sv | 137 +++++++++++++
 tb/tb_tdm_demux4.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux4_pkg.sv
// Shared types and constants for the 4-lane TDM demultiplexer.
package tdm_demux4_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  typedef logic [1:0] slot_t;

  localparam slot_t SLOT_LAST = 2'd3;

endpackage

// File: rtl/tdm_demux4_demux2.sv
// 1:2 enable decoder; the receive-side mirror of the mux2 cell.
module demux2 (
  input  logic en,
  input  logic sel,
  output logic z0,
  output logic z1
);

  assign z0 = en & ~sel;
  assign z1 = en &  sel;

endmodule

// File: rtl/tdm_demux4.sv
// 4-lane time-division demultiplexer. Words arrive in rotating slots with
// lane 0 flagged by sync; each word lands in its lane holding register and
// frame_valid pulses once a complete lane 0..3 frame has been captured.
// Optional build macro TDM_DEMUX4_ERRCNT_EN adds a saturating 8-bit
// framing-error counter on port err_count.
//
// state    | meaning
// ---------+---------------------------------------------------------
// UNLOCKED | waiting for a sync word; unsynchronised words are dropped
// LOCKED   | slot tracks the lane expected for the next valid word
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         sync,
  input  logic [W-1:0] d,
  output logic [W-1:0] q0,
  output logic [W-1:0] q1,
  output logic [W-1:0] q2,
  output logic [W-1:0] q3,
  output logic         frame_valid,
  output logic         locked,
`ifdef TDM_DEMUX4_ERRCNT_EN
  output logic [7:0]   err_count,
`endif
  output logic         sync_err
);

  state_t     state;
  slot_t      slot;
  logic       wr_en;
  slot_t      wr_lane;
  logic       en_lo;
  logic       en_hi;
  logic [3:0] lane_en;
  logic       err_det;

  // A sync word always targets lane 0; otherwise only a locked, non-zero
  // slot is a legal destination (slot 0 without sync is a framing error).
  assign wr_en   = in_valid & (sync | ((state == LOCKED) & (slot != 2'd0)));
  assign wr_lane = sync ? 2'd0 : slot;

  assign err_det = in_valid & (state == LOCKED) &
                   (sync ? (slot != 2'd0) : (slot == 2'd0));

  assign locked = (state == LOCKED);

  demux2 u_root (
    .en  (wr_en),
    .sel (wr_lane[1]),
    .z0  (en_lo),
    .z1  (en_hi)
  );

  demux2 u_leaf_lo (
    .en  (en_lo),
    .sel (wr_lane[0]),
    .z0  (lane_en[0]),
    .z1  (lane_en[1])
  );

  demux2 u_leaf_hi (
    .en  (en_hi),
    .sel (wr_lane[0]),
    .z0  (lane_en[2]),
    .z1  (lane_en[3])
  );

  // Lane holding registers: only the decoded lane loads, the rest hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q0 <= '0;
      q1 <= '0;
      q2 <= '0;
      q3 <= '0;
    end else begin
      if (lane_en[0]) q0 <= d;
      if (lane_en[1]) q1 <= d;
      if (lane_en[2]) q2 <= d;
      if (lane_en[3]) q3 <= d;
    end
  end

  // Framing FSM with slot tracking and registered frame/error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= UNLOCKED;
      slot        <= 2'd0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= err_det;
      if (in_valid) begin
        case (state)
          UNLOCKED: begin
            if (sync) begin
              state <= LOCKED;
              slot  <= 2'd1;
            end
          end
          LOCKED: begin
            if (sync) begin
              slot <= 2'd1;
            end else if (slot == 2'd0) begin
              state <= UNLOCKED;
              slot  <= 2'd0;
            end else begin
              frame_valid <= (slot == SLOT_LAST);
              slot        <= slot + 2'd1;
            end
          end
          default: begin
            state <= UNLOCKED;
            slot  <= 2'd0;
          end
        endcase
      end
    end
  end

`ifdef TDM_DEMUX4_ERRCNT_EN
  // Saturating count of framing errors, counted on the edge that raises sync_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= 8'd0;
    end else if (err_det && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed scenarios plus a randomized
// run against a frame-level reference model.
module tb_tdm_demux4;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         sync = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] q0, q1, q2, q3;
  logic         frame_valid, locked, sync_err;
`ifdef TDM_DEMUX4_ERRCNT_EN
  logic [7:0]   err_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [7:0] m_q [4];
  bit         m_locked;
  int         m_pos;
  bit         m_fv;
  bit         m_err;
  int         m_cnt;

  tdm_demux4 #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .sync        (sync),
    .d           (d),
    .q0          (q0),
    .q1          (q1),
    .q2          (q2),
    .q3          (q3),
    .frame_valid (frame_valid),
    .locked      (locked),
`ifdef TDM_DEMUX4_ERRCNT_EN
    .err_count   (err_count),
`endif
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  // Frame-level view: m_pos is the position within the current frame.
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 4; i++) m_q[i] = 8'h00;
      m_locked = 0; m_pos = 0; m_fv = 0; m_err = 0; m_cnt = 0;
    end else begin
      m_fv = 0; m_err = 0;
      if (in_valid) begin
        if (!m_locked) begin
          if (sync) begin m_q[0] = d; m_pos = 1; m_locked = 1; end
        end else if (sync) begin
          m_err = (m_pos != 0);
          m_q[0] = d; m_pos = 1;
        end else if (m_pos == 0) begin
          m_err = 1; m_locked = 0;
        end else begin
          m_q[m_pos] = d;
          m_fv = (m_pos == 3);
          m_pos = (m_pos + 1) % 4;
        end
        if (m_err && m_cnt < 255) m_cnt++;
      end
    end
  endtask

  task automatic step(input bit v, input bit s, input logic [7:0] dv);
    rst = 0; in_valid = v; sync = s; d = dv;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; sync = 0; d = '0;
    @(posedge clk);
    model_edge();
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({q0, q1, q2, q3} !== 32'h0) begin
      n_fail++; $display("FAIL reset_q act=%h exp=%h", {q0, q1, q2, q3}, 32'h0);
    end
    n_tests++;
    if ({frame_valid, locked, sync_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags act=%b exp=000", {frame_valid, locked, sync_err});
    end
`ifdef TDM_DEMUX4_ERRCNT_EN
    n_tests++;
    if (err_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_errcnt act=%0d exp=0", err_count);
    end
`endif
  endtask

  task automatic test_basic_frame();
    bit err_seen = 0;
    do_reset();
    step(1, 1, 8'hA0); err_seen |= sync_err;
    n_tests++;
    if ({q0, locked, frame_valid} !== {8'hA0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL basic_lane0 act q0=%h lk=%b fv=%b exp q0=a0 lk=1 fv=0", q0, locked, frame_valid);
    end
    step(1, 0, 8'hB1); err_seen |= sync_err;
    step(1, 0, 8'hC2); err_seen |= sync_err;
    n_tests++;
    if (frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_early_fv act=%b exp=0", frame_valid);
    end
    step(1, 0, 8'hD3); err_seen |= sync_err;
    n_tests++;
    if ({q0, q1, q2, q3, frame_valid, locked} !== {32'hA0B1C2D3, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL basic_frame act=%h fv=%b lk=%b exp=a0b1c2d3 fv=1 lk=1", {q0, q1, q2, q3}, frame_valid, locked);
    end
    step(0, 0, 8'h00); err_seen |= sync_err;
    n_tests++;
    if (frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_fv_width act=%b exp=0", frame_valid);
    end
    n_tests++;
    if (err_seen !== 1'b0) begin
      n_fail++; $display("FAIL basic_no_err act=%b exp=0", err_seen);
    end
  endtask

  task automatic test_no_sync();
    do_reset();
    step(1, 0, 8'h11);
    step(1, 0, 8'h22);
    n_tests++;
    if ({q0, q1, q2, q3, locked, sync_err} !== {32'h0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL nosync_drop act=%h lk=%b err=%b exp=0 lk=0 err=0", {q0, q1, q2, q3}, locked, sync_err);
    end
    step(1, 1, 8'h33);
    n_tests++;
    if ({q0, locked} !== {8'h33, 1'b1}) begin
      n_fail++; $display("FAIL nosync_lock act q0=%h lk=%b exp q0=33 lk=1", q0, locked);
    end
  endtask

  task automatic test_sync_midframe();
    do_reset();
    step(1, 1, 8'h01);
    step(1, 0, 8'h02);
    step(1, 1, 8'h55);
    n_tests++;
    if ({sync_err, frame_valid, locked, q0, q1} !== {3'b101, 8'h55, 8'h02}) begin
      n_fail++; $display("FAIL midsync_err act err=%b fv=%b lk=%b q0=%h q1=%h exp err=1 fv=0 lk=1 q0=55 q1=02",
                         sync_err, frame_valid, locked, q0, q1);
    end
    step(1, 0, 8'h66);
    n_tests++;
    if ({sync_err, frame_valid} !== 2'b00) begin
      n_fail++; $display("FAIL midsync_pulse act err=%b fv=%b exp 00", sync_err, frame_valid);
    end
    step(1, 0, 8'h77);
    step(1, 0, 8'h88);
    n_tests++;
    if ({q0, q1, q2, q3, frame_valid} !== {32'h55667788, 1'b1}) begin
      n_fail++; $display("FAIL midsync_frame act=%h fv=%b exp=55667788 fv=1", {q0, q1, q2, q3}, frame_valid);
    end
  endtask

  task automatic test_unlock();
    step(1, 0, 8'h9A);
    n_tests++;
    if ({sync_err, locked, q0} !== {2'b10, 8'h55}) begin
      n_fail++; $display("FAIL unlock act err=%b lk=%b q0=%h exp err=1 lk=0 q0=55", sync_err, locked, q0);
    end
    step(0, 0, 8'h00);
    n_tests++;
    if ({sync_err, locked} !== 2'b00) begin
      n_fail++; $display("FAIL unlock_after act err=%b lk=%b exp 00", sync_err, locked);
    end
  endtask

  task automatic test_idle_gaps();
    int fv_cnt = 0;
    do_reset();
    step(1, 1, 8'hAA);
    step(1, 0, 8'hBB);
    for (int i = 0; i < 3; i++) begin
      step(0, i[0], 8'hEE);
      n_tests++;
      if ({q0, q1, q2, q3, frame_valid, locked} !== {32'hAABB0000, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL idle_hold%0d act=%h fv=%b lk=%b exp=aabb0000 fv=0 lk=1", i, {q0, q1, q2, q3}, frame_valid, locked);
      end
    end
    step(1, 0, 8'hCC); fv_cnt += frame_valid;
    step(1, 0, 8'hDD); fv_cnt += frame_valid;
    n_tests++;
    if ({q0, q1, q2, q3, frame_valid} !== {32'hAABBCCDD, 1'b1}) begin
      n_fail++; $display("FAIL idle_resume act=%h fv=%b exp=aabbccdd fv=1", {q0, q1, q2, q3}, frame_valid);
    end
    step(0, 0, 8'h00); fv_cnt += frame_valid;
    n_tests++;
    if (fv_cnt !== 1) begin
      n_fail++; $display("FAIL idle_fv_count act=%0d exp=1", fv_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    step(1, 1, 8'h10);
    step(1, 0, 8'h20);
    step(1, 0, 8'h30);
    do_reset();
    n_tests++;
    if ({q0, q1, q2, q3, frame_valid, locked, sync_err} !== 35'h0) begin
      n_fail++; $display("FAIL rstmid_clear act=%h flags=%b exp=0 flags=000", {q0, q1, q2, q3}, {frame_valid, locked, sync_err});
    end
    step(1, 0, 8'h40);
    n_tests++;
    if ({q3, frame_valid, locked} !== 10'h0) begin
      n_fail++; $display("FAIL rstmid_nofv act q3=%h fv=%b lk=%b exp 0 0 0", q3, frame_valid, locked);
    end
    step(1, 1, 8'h41);
    step(1, 0, 8'h42);
    step(1, 0, 8'h43);
    step(1, 0, 8'h44);
    n_tests++;
    if ({q0, q1, q2, q3, frame_valid, sync_err} !== {32'h41424344, 2'b10}) begin
      n_fail++; $display("FAIL rstmid_frame act=%h fv=%b err=%b exp=41424344 fv=1 err=0", {q0, q1, q2, q3}, frame_valid, sync_err);
    end
  endtask

  task automatic test_random();
    bit v, s;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        v = ($urandom_range(0, 3) != 0);
        if (m_pos == 0) s = ($urandom_range(0, 9) < 8);
        else            s = ($urandom_range(0, 9) == 0);
        step(v, s, 8'($urandom));
      end
      n_tests++;
      if ({q0, q1, q2, q3, frame_valid, locked, sync_err} !==
          {m_q[0], m_q[1], m_q[2], m_q[3], m_fv, m_locked, m_err}) begin
        n_fail++;
        $display("FAIL random cyc=%0d act=%h/%b exp=%h/%b", i, {q0, q1, q2, q3}, {frame_valid, locked, sync_err},
                 {m_q[0], m_q[1], m_q[2], m_q[3]}, {m_fv, m_locked, m_err});
      end
`ifdef TDM_DEMUX4_ERRCNT_EN
      n_tests++;
      if (err_count !== 8'(m_cnt)) begin
        n_fail++; $display("FAIL random_errcnt cyc=%0d act=%0d exp=%0d", i, err_count, m_cnt);
      end
`endif
    end
  endtask

`ifdef TDM_DEMUX4_ERRCNT_EN
  task automatic test_errcnt();
    do_reset();
    step(1, 1, 8'h00);
    for (int i = 0; i < 10; i++) step(1, 1, 8'(i));
    n_tests++;
    if (err_count !== 8'd10) begin
      n_fail++; $display("FAIL errcnt_ten act=%0d exp=10", err_count);
    end
    for (int i = 10; i < 300; i++) step(1, 1, 8'(i));
    n_tests++;
    if (err_count !== 8'd255) begin
      n_fail++; $display("FAIL errcnt_sat act=%0d exp=255", err_count);
    end
    do_reset();
    n_tests++;
    if (err_count !== 8'd0) begin
      n_fail++; $display("FAIL errcnt_rst act=%0d exp=0", err_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_no_sync();
    test_sync_midframe();
    test_unlock();
    test_idle_gaps();
    test_reset_midframe();
    test_random();
`ifdef TDM_DEMUX4_ERRCNT_EN
    test_errcnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
